pci_io_initiator: RTL and testbench

Single-master PCI initiator that turns a local valid/ready request into one 32-bit PCI I/O read or write transaction, single data phase, and returns the result on a one-cycle response strobe. It sits directly upstream of the PCI I/O RAM target on the same bus: it produces the FRAMEn/IRDYn/AD/CBE traffic that target decodes, and it consumes that target's DEVSELn/TRDYn handshake. It also serves as the bench driver for that target.

---
 rtl/pci_pkg.sv | 24 ++
 rtl/pci_io_initiator.sv | 179 +++++++++++++++++
 tb/tb_pci_io_initiator.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pci_pkg.sv
// Shared PCI definitions: I/O command codes, data-phase byte enables and initiator state encoding.
package pci_pkg;

    localparam int ABORT_CYCLES = 5;
    localparam int ABORT_W      = $clog2(ABORT_CYCLES);

    localparam logic [3:0]  IO_READ_CMD  = 4'b0010;
    localparam logic [3:0]  IO_WRITE_CMD = 4'b0011;
    localparam logic [3:0]  DATA_BE      = 4'b0000;
    localparam logic [31:0] DWORD_MASK   = 32'hFFFF_FFFC;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ADDR,
        DATA,
        TURN
    } initState_t;

    function automatic logic [3:0] ioCmd(input logic isWrite);
        return isWrite ? IO_WRITE_CMD : IO_READ_CMD;
    endfunction

endpackage

// File: rtl/pci_io_initiator.sv
// Single-master PCI I/O initiator: one local request becomes one single-data-phase I/O cycle.
// States: IDLE accept request | REQ wait for grant | ADDR address phase | DATA data phase | TURN release + respond
module pci_io_initiator
    import pci_pkg::*;
(
    input  logic             PCI_CLK,
    input  logic             PCI_RSTn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_error,
    output logic             PCI_REQn,
    input  logic             PCI_GNTn,
    output wire logic        PCI_FRAMEn,
    output wire logic        PCI_IRDYn,
    inout  wire logic [31:0] PCI_AD,
    output wire logic [3:0]  PCI_CBE,
    input  logic             PCI_TRDYn,
    input  logic             PCI_DEVSELn
);

    localparam logic [ABORT_W-1:0] ABORT_LOAD = ABORT_W'(ABORT_CYCLES - 1);

    initState_t         state;
    initState_t         nextState;
    logic               isWrite;
    logic [31:0]        addrReg;
    logic [31:0]        wdataReg;
    logic [ABORT_W-1:0] abortCnt;
    logic               devselSeen;
    logic               dataDone;
    logic               masterAbort;
    logic               busIdle;

    logic               reqN, reqNNxt;
    logic               frameOe, frameOeNxt, frameOut, frameOutNxt;
    logic               irdyOe, irdyOeNxt, irdyOut, irdyOutNxt;
    logic               adOe, adOeNxt;
    logic [31:0]        adOut, adOutNxt;
    logic               cbeOe, cbeOeNxt;
    logic [3:0]         cbeOut, cbeOutNxt;
    logic               rspValid;
    logic               rspError;
    logic [31:0]        rspRdata;

    // We are the only master, so the bus is idle unless we are driving FRAMEn/IRDYn low.
    assign busIdle = (!frameOe || frameOut) && (!irdyOe || irdyOut);

    always_comb begin
        nextState   = state;
        dataDone    = 1'b0;
        masterAbort = 1'b0;
        case (state)
            IDLE: if (req_valid) nextState = REQ;
            REQ:  if (!PCI_GNTn && busIdle) nextState = ADDR;
            ADDR: nextState = DATA;
            DATA: begin
                if (!PCI_DEVSELn && !PCI_TRDYn) begin
                    dataDone  = 1'b1;
                    nextState = TURN;
                end else if (PCI_DEVSELn && !devselSeen && abortCnt == '0) begin
                    masterAbort = 1'b1;
                    nextState   = TURN;
                end
            end
            TURN:    nextState = IDLE;
            default: nextState = IDLE;
        endcase

        reqNNxt     = 1'b1;
        frameOeNxt  = 1'b0;
        frameOutNxt = 1'b1;
        irdyOeNxt   = 1'b0;
        irdyOutNxt  = 1'b1;
        adOeNxt     = 1'b0;
        adOutNxt    = '0;
        cbeOeNxt    = 1'b0;
        cbeOutNxt   = '0;
        case (nextState)
            REQ: reqNNxt = 1'b0;
            ADDR: begin
                frameOeNxt  = 1'b1;
                frameOutNxt = 1'b0;
                irdyOeNxt   = 1'b1;
                adOeNxt     = 1'b1;
                adOutNxt    = addrReg;
                cbeOeNxt    = 1'b1;
                cbeOutNxt   = ioCmd(isWrite);
            end
            DATA: begin
                frameOeNxt = 1'b1;
                irdyOeNxt  = 1'b1;
                irdyOutNxt = 1'b0;
                adOeNxt    = isWrite;
                adOutNxt   = wdataReg;
                cbeOeNxt   = 1'b1;
                cbeOutNxt  = DATA_BE;
            end
            TURN: begin
                frameOeNxt = 1'b1;
                irdyOeNxt  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCI_CLK) begin
        if (!PCI_RSTn) state <= IDLE;
        else           state <= nextState;
    end

    always_ff @(posedge PCI_CLK) begin
        if (!PCI_RSTn) begin
            isWrite    <= 1'b0;
            addrReg    <= '0;
            wdataReg   <= '0;
            abortCnt   <= ABORT_LOAD;
            devselSeen <= 1'b0;
            reqN       <= 1'b1;
            frameOe    <= 1'b0;
            frameOut   <= 1'b1;
            irdyOe     <= 1'b0;
            irdyOut    <= 1'b1;
            adOe       <= 1'b0;
            adOut      <= '0;
            cbeOe      <= 1'b0;
            cbeOut     <= '0;
            rspValid   <= 1'b0;
            rspError   <= 1'b0;
            rspRdata   <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                isWrite  <= req_write;
                addrReg  <= req_addr & DWORD_MASK;
                wdataReg <= req_wdata;
            end
            // Abort timer only runs until the target claims; after that wait states are unbounded.
            if (state == ADDR) begin
                abortCnt   <= ABORT_LOAD;
                devselSeen <= 1'b0;
            end else if (state == DATA) begin
                if (!PCI_DEVSELn)                    devselSeen <= 1'b1;
                if (!devselSeen && abortCnt != '0)   abortCnt   <= abortCnt - 1'b1;
            end
            reqN     <= reqNNxt;
            frameOe  <= frameOeNxt;
            frameOut <= frameOutNxt;
            irdyOe   <= irdyOeNxt;
            irdyOut  <= irdyOutNxt;
            adOe     <= adOeNxt;
            adOut    <= adOutNxt;
            cbeOe    <= cbeOeNxt;
            cbeOut   <= cbeOutNxt;
            rspValid <= (nextState == TURN);
            if (dataDone) begin
                rspError <= 1'b0;
                rspRdata <= isWrite ? 32'h0 : PCI_AD;
            end else if (masterAbort) begin
                rspError <= 1'b1;
                rspRdata <= 32'hFFFF_FFFF;
            end
        end
    end

    assign req_ready  = (state == IDLE);
    assign rsp_valid  = rspValid;
    assign rsp_error  = rspError;
    assign rsp_rdata  = rspRdata;
    assign PCI_REQn   = reqN;
    assign PCI_FRAMEn = frameOe ? frameOut : 1'bz;
    assign PCI_IRDYn  = irdyOe  ? irdyOut  : 1'bz;
    assign PCI_AD     = adOe    ? adOut    : {32{1'bz}};
    assign PCI_CBE    = cbeOe   ? cbeOut   : {4{1'bz}};

endmodule

// File: tb/tb_pci_io_initiator.sv
// Bench for pci_io_initiator: behavioural I/O RAM target at 0x200 plus a word-array reference model.
module tb_pci_io_initiator;

    localparam logic [3:0] CMD_RD = 4'b0010;
    localparam logic [3:0] CMD_WR = 4'b0011;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    wire         req_ready;
    wire         rsp_valid;
    wire         rsp_error;
    wire  [31:0] rsp_rdata;
    wire         reqN;
    logic        gntN = 1'b0;
    logic        trdyN = 1'b1;
    logic        devN = 1'b1;
    tri1         frameN;
    tri1         irdyN;
    tri1  [31:0] ad;
    tri1  [3:0]  cbe;

    pci_io_initiator dut (
        .PCI_CLK(clk), .PCI_RSTn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .PCI_REQn(reqN), .PCI_GNTn(gntN), .PCI_FRAMEn(frameN), .PCI_IRDYn(irdyN),
        .PCI_AD(ad), .PCI_CBE(cbe), .PCI_TRDYn(trdyN), .PCI_DEVSELn(devN)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passCnt = 0;
    int checkCnt = 0;

    // ---------------- behavioural target: 16 words at 0x200 ----------------
    logic [31:0] tMem [16];
    logic [31:0] refMem [16];
    bit          memLoaded = 1'b0;
    int          tgtWait = 0;
    int          tPh = 0;
    int          tCnt = 0;
    logic [3:0]  tIdx = '0;
    logic        tWr = 1'b0;
    logic        tOe = 1'b0;
    logic [31:0] tData = '0;

    assign ad = tOe ? tData : {32{1'bz}};

    function automatic logic [31:0] initWord(input int i);
        return 32'hA5A5_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    function automatic bit tgtHit(input logic [31:0] a);
        return a[31:6] == 26'h8;
    endfunction

    always @(posedge clk) begin
        if (!memLoaded) begin
            for (int i = 0; i < 16; i++) tMem[i] <= initWord(i);
            memLoaded <= 1'b1;
        end
        if (!rstn) begin
            devN <= 1'b1; trdyN <= 1'b1; tOe <= 1'b0; tPh <= 0;
        end else begin
            case (tPh)
                0: if (frameN === 1'b0 && tgtHit(ad) && (cbe === CMD_RD || cbe === CMD_WR)) begin
                    tIdx <= ad[5:2];
                    tWr  <= (cbe === CMD_WR);
                    devN <= 1'b0;
                    if (cbe === CMD_WR && tgtWait == 0) begin
                        trdyN <= 1'b0; tPh <= 2;
                    end else begin
                        tCnt <= (cbe === CMD_WR) ? tgtWait - 1 : tgtWait;
                        tPh  <= 1;
                    end
                end
                1: if (tCnt == 0) begin
                    trdyN <= 1'b0;
                    if (!tWr) begin tOe <= 1'b1; tData <= tMem[tIdx]; end
                    tPh <= 2;
                end else tCnt <= tCnt - 1;
                2: if (irdyN === 1'b0) begin
                    if (tWr) tMem[tIdx] <= ad;
                    devN <= 1'b1; trdyN <= 1'b1; tOe <= 1'b0; tPh <= 0;
                end
                default: tPh <= 0;
            endcase
        end
    end

    // ---------------- transaction driver / observer ----------------
    int          lastAddrCyc, lastRspCyc;
    logic [31:0] lastAd, lastD1Ad, lastRdata;
    logic [3:0]  lastCbe, lastD1Cbe;
    logic        lastErr;

    // Called at a negedge; returns at the negedge of the response cycle (or on timeout).
    task automatic runTxn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        lastAddrCyc = -1; lastRspCyc = -1;
        lastAd = '0; lastD1Ad = '0; lastCbe = '0; lastD1Cbe = '0;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (lastRspCyc < 0 && n < 200) begin
            if (frameN === 1'b0) begin lastAddrCyc = cyc; lastAd = ad; lastCbe = cbe; end
            if (lastAddrCyc >= 0 && cyc == lastAddrCyc + 1) begin lastD1Ad = ad; lastD1Cbe = cbe; end
            if (rsp_valid === 1'b1) begin lastRspCyc = cyc; lastRdata = rsp_rdata; lastErr = rsp_error; end
            if (lastRspCyc < 0) begin @(negedge clk); n++; end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checkCnt++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else passCnt++;
        checkCnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rspvalid: got %b want 0", rsp_valid); else passCnt++;
        checkCnt++; if (rsp_error !== 1'b0) $display("FAIL reset_rsperror: got %b want 0", rsp_error); else passCnt++;
        checkCnt++; if (rsp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rsp_rdata); else passCnt++;
        checkCnt++; if (reqN !== 1'b1) $display("FAIL reset_reqn: got %b want 1", reqN); else passCnt++;
        checkCnt++; if (frameN !== 1'b1 || irdyN !== 1'b1) $display("FAIL reset_frame_irdy: got %b%b want 11 (released)", frameN, irdyN); else passCnt++;
        checkCnt++; if (ad !== 32'hFFFF_FFFF || cbe !== 4'hF) $display("FAIL reset_ad_cbe: got %h/%h want released", ad, cbe); else passCnt++;
    endtask

    task automatic test_write();
        runTxn(1'b1, 32'h0000_0204, 32'hDEAD_BEEF);
        refMem[1] = 32'hDEAD_BEEF;
        checkCnt++; if (lastAd !== 32'h0000_0204) $display("FAIL write_addr: got %h want 00000204", lastAd); else passCnt++;
        checkCnt++; if (lastCbe !== CMD_WR) $display("FAIL write_cmd: got %b want 0011", lastCbe); else passCnt++;
        checkCnt++; if (lastD1Ad !== 32'hDEAD_BEEF || lastD1Cbe !== 4'b0000) $display("FAIL write_data_phase: got %h/%b want deadbeef/0000", lastD1Ad, lastD1Cbe); else passCnt++;
        checkCnt++; if (lastRspCyc - lastAddrCyc != 2 || lastRspCyc < 0) $display("FAIL write_latency: got %0d want 2", lastRspCyc - lastAddrCyc); else passCnt++;
        checkCnt++; if (lastErr !== 1'b0 || lastRdata !== 32'h0) $display("FAIL write_rsp: got err %b data %h want 0/0", lastErr, lastRdata); else passCnt++;
        checkCnt++; if (req_ready !== 1'b0) $display("FAIL write_ready_in_turn: got %b want 0", req_ready); else passCnt++;
        @(negedge clk);
        checkCnt++; if (req_ready !== 1'b1) $display("FAIL write_ready_after: got %b want 1", req_ready); else passCnt++;
        checkCnt++; if (tMem[1] !== 32'hDEAD_BEEF) $display("FAIL write_target_word: got %h want deadbeef", tMem[1]); else passCnt++;
    endtask

    task automatic test_read();
        runTxn(1'b0, 32'h0000_0204, 32'h0);
        checkCnt++; if (lastCbe !== CMD_RD) $display("FAIL read_cmd: got %b want 0010", lastCbe); else passCnt++;
        checkCnt++; if (lastD1Ad !== 32'hFFFF_FFFF) $display("FAIL read_turnaround: got %h want released bus", lastD1Ad); else passCnt++;
        checkCnt++; if (lastRspCyc - lastAddrCyc != 3 || lastRspCyc < 0) $display("FAIL read_latency: got %0d want 3", lastRspCyc - lastAddrCyc); else passCnt++;
        checkCnt++; if (lastRdata !== refMem[1] || lastErr !== 1'b0) $display("FAIL read_data: got %h err %b want %h err 0", lastRdata, lastErr, refMem[1]); else passCnt++;
        @(negedge clk);
        checkCnt++; if (rsp_rdata !== refMem[1]) $display("FAIL read_hold: got %h want %h", rsp_rdata, refMem[1]); else passCnt++;
    endtask

    task automatic test_abort();
        runTxn(1'b0, 32'h0000_0400, 32'h0);
        checkCnt++; if (lastAd !== 32'h0000_0400) $display("FAIL abort_addr: got %h want 00000400", lastAd); else passCnt++;
        checkCnt++; if (lastRspCyc - lastAddrCyc != 6 || lastRspCyc < 0) $display("FAIL abort_latency: got %0d want 6", lastRspCyc - lastAddrCyc); else passCnt++;
        checkCnt++; if (lastErr !== 1'b1) $display("FAIL abort_err: got %b want 1", lastErr); else passCnt++;
        checkCnt++; if (lastRdata !== 32'hFFFF_FFFF) $display("FAIL abort_data: got %h want ffffffff", lastRdata); else passCnt++;
    endtask

    task automatic test_grant_wait();
        int n, aC, rC;
        logic [31:0] wd;
        wd = $urandom;
        @(negedge clk);
        gntN = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_020C; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checkCnt++; if (reqN !== 1'b0 || frameN !== 1'b1) $display("FAIL grant_wait_%0d: reqn %b frame %b want 0/1", i, reqN, frameN); else passCnt++;
            @(negedge clk);
        end
        gntN = 1'b0;
        @(negedge clk);
        aC = cyc;
        checkCnt++; if (frameN !== 1'b0) $display("FAIL grant_frame: got %b want 0", frameN); else passCnt++;
        checkCnt++; if (reqN !== 1'b1) $display("FAIL grant_reqn_addr: got %b want 1", reqN); else passCnt++;
        gntN = 1'b1;
        n = 0; rC = -1;
        while (rC < 0 && n < 20) begin
            @(negedge clk); n++;
            if (rsp_valid === 1'b1) rC = cyc;
        end
        refMem[3] = wd;
        checkCnt++; if (rC - aC != 2 || rC < 0) $display("FAIL grant_latency: got %0d want 2", rC - aC); else passCnt++;
        checkCnt++; if (rsp_error !== 1'b0) $display("FAIL grant_err: got %b want 0", rsp_error); else passCnt++;
        checkCnt++; if (tMem[3] !== wd) $display("FAIL grant_target_word: got %h want %h", tMem[3], wd); else passCnt++;
        gntN = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        bit sawRsp;
        tgtWait = 3;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0208; req_wdata = 32'hCAFE_F00D;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (irdyN !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        checkCnt++; if (irdyN !== 1'b0) $display("FAIL rstmid_reach_data: irdy %b want 0", irdyN); else passCnt++;
        rstn = 1'b0;
        @(negedge clk);
        checkCnt++; if (frameN !== 1'b1 || irdyN !== 1'b1) $display("FAIL rstmid_frame_irdy: got %b%b want released", frameN, irdyN); else passCnt++;
        checkCnt++; if (ad !== 32'hFFFF_FFFF || cbe !== 4'hF) $display("FAIL rstmid_ad_cbe: got %h/%h want released", ad, cbe); else passCnt++;
        checkCnt++; if (reqN !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL rstmid_reqn_rsp: reqn %b rspvalid %b want 1/0", reqN, rsp_valid); else passCnt++;
        rstn = 1'b1;
        sawRsp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) sawRsp = 1'b1;
        end
        checkCnt++; if (sawRsp) $display("FAIL rstmid_no_rsp: got rsp_valid pulse want none"); else passCnt++;
        checkCnt++; if (tMem[2] !== refMem[2]) $display("FAIL rstmid_target_untouched: got %h want %h", tMem[2], refMem[2]); else passCnt++;
        tgtWait = 0;
        runTxn(1'b1, 32'h0000_0208, 32'h1234_5678);
        refMem[2] = 32'h1234_5678;
        checkCnt++; if (lastRspCyc - lastAddrCyc != 2 || lastRspCyc < 0 || lastErr !== 1'b0) $display("FAIL rstmid_followup: lat %0d err %b want 2/0", lastRspCyc - lastAddrCyc, lastErr); else passCnt++;
        checkCnt++; if (tMem[2] !== 32'h1234_5678) $display("FAIL rstmid_followup_word: got %h want 12345678", tMem[2]); else passCnt++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int addrCycs[$];
        int rspCycs[$];
        logic errs[$];
        int accepts, n;
        logic [31:0] wA, wB;
        wA = $urandom; wB = $urandom;
        accepts = 0; n = 0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0210; req_wdata = wA;
        while (rspCycs.size() < 2 && n < 100) begin
            if (frameN === 1'b0) addrCycs.push_back(cyc);
            if (rsp_valid === 1'b1) begin rspCycs.push_back(cyc); errs.push_back(rsp_error); end
            if (req_valid && req_ready === 1'b1) accepts++;
            @(negedge clk); n++;
            if (accepts == 1) begin req_addr = 32'h0000_0214; req_wdata = wB; end
            if (accepts >= 2) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        refMem[4] = wA; refMem[5] = wB;
        checkCnt++;
        if (addrCycs.size() != 2 || rspCycs.size() != 2) $display("FAIL b2b_count: addr %0d rsp %0d want 2/2", addrCycs.size(), rspCycs.size());
        else begin
            passCnt++;
            checkCnt++; if (addrCycs[1] - rspCycs[0] != 3) $display("FAIL b2b_gap: got %0d want 3", addrCycs[1] - rspCycs[0]); else passCnt++;
            checkCnt++; if (errs[0] !== 1'b0 || errs[1] !== 1'b0) $display("FAIL b2b_err: got %b%b want 00", errs[0], errs[1]); else passCnt++;
        end
        checkCnt++; if (tMem[4] !== wA || tMem[5] !== wB) $display("FAIL b2b_words: got %h %h want %h %h", tMem[4], tMem[5], wA, wB); else passCnt++;
    endtask

    task automatic test_random();
        logic        wr, miss;
        int          idx, w, expLat;
        logic [31:0] addr, wd, expData;
        logic        expErr;
        for (int t = 0; t < 30; t++) begin
            wr   = 1'($urandom_range(0, 1));
            miss = ($urandom_range(0, 7) == 0);
            idx  = $urandom_range(0, 15);
            wd   = $urandom;
            w    = $urandom_range(0, 3);
            addr = miss ? (32'h0000_0400 + 32'($urandom_range(0, 255)))
                        : (32'h0000_0200 + 32'(idx * 4) + 32'($urandom_range(0, 3)));
            tgtWait = w;
            if (miss) begin
                expErr = 1'b1; expData = 32'hFFFF_FFFF; expLat = 6;
            end else if (wr) begin
                expErr = 1'b0; expData = 32'h0; expLat = 2 + w;
            end else begin
                expErr = 1'b0; expData = refMem[idx]; expLat = 3 + w;
            end
            runTxn(wr, addr, wd);
            if (!miss && wr) refMem[idx] = wd;
            checkCnt++; if (lastRspCyc < 0 || lastRspCyc - lastAddrCyc != expLat) $display("FAIL rand%0d_latency: got %0d want %0d", t, lastRspCyc - lastAddrCyc, expLat); else passCnt++;
            checkCnt++; if (lastErr !== expErr) $display("FAIL rand%0d_err: got %b want %b", t, lastErr, expErr); else passCnt++;
            checkCnt++; if (lastRdata !== expData) $display("FAIL rand%0d_data: got %h want %h", t, lastRdata, expData); else passCnt++;
        end
        tgtWait = 0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            checkCnt++; if (tMem[i] !== refMem[i]) $display("FAIL final_word%0d: got %h want %h", i, tMem[i], refMem[i]); else passCnt++;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) refMem[i] = initWord(i);
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_grant_wait();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passCnt, checkCnt);
        $fatal(1, "watchdog");
    end

endmodule
